addsub_operand_issuer: RTL and testbench
========================================

Name: addsub_operand_issuer

Overview:
Upstream stimulus/operand stage for the 4-bit adder_subtractor. Drives its A, B and M inputs from registered outputs, in one of two modes:
- Queued mode: operand triples arrive over a valid/ready handshake, are buffered in a small FIFO and issued in order.
- Sweep mode: the block generates the exhaustive {A,B,M} increment sequence in hardware.
A downstream capture stage consumes each issued triple via issue_ready.

Parameters:
WIDTH, 4, operand width of A and B
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_A/in_B/in_M hold a valid triple
in_ready  output  1  FIFO can accept a triple
in_A  input  WIDTH  operand A to enqueue
in_B  input  WIDTH  operand B to enqueue
in_M  input  1  mode to enqueue (0 add, 1 subtract)
sweep_en  input  1  request/hold exhaustive sweep
issue_ready  input  1  downstream accepts current triple
A  output  WIDTH  operand A to adder_subtractor
B  output  WIDTH  operand B to adder_subtractor
M  output  1  mode to adder_subtractor
out_valid  output  1  A/B/M hold a valid triple
count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
sweep_done  output  1  one-cycle pulse at end of sweep

Behaviour:
- One clock, clk. Reset rst is asynchronous, active-high. While rst is high:
  - A, B, M, out_valid, count, sweep_done are all 0.
  - in_ready = 1 once rst is released.
  - FIFO pointers cleared; state = QUEUE.
- Transfer rules:
  - Push: in_valid && in_ready at a rising edge.
  - Accept: out_valid && issue_ready at a rising edge.
  - A/B/M stay stable while out_valid=1 and issue_ready=0.
- States: QUEUE, SWEEP.
- QUEUE state:
  - in_ready = (count < DEPTH). Push into a full FIFO is blocked even if a pop occurs in the same cycle.
  - Output register loads the FIFO head at an edge when out_valid=0, or when an accept occurs, provided count > 0. out_valid then = 1.
  - If an accept occurs with count == 0, out_valid goes to 0.
  - Latency: a push into an empty FIFO with out_valid=0 appears on A/B/M, with out_valid=1, after the following edge (2 edges from the push).
  - Push and load in the same cycle: count unchanged. Triples issue strictly in push order.
  - Pointers wrap modulo DEPTH.
- QUEUE -> SWEEP: at an edge where sweep_en=1, count==0 and out_valid=0. If any of those conditions fails, sweep_en is ignored until the FIFO drains.
- SWEEP state:
  - in_ready = 0.
  - {A,B,M} is a (2*WIDTH+1)-bit counter, loaded 0 on entry, with out_valid=1.
  - Each accept increments {A,B,M} by 1.
  - Accepting the all-ones value {A=F,B=F,M=1} ends the sweep: next edge sets sweep_done=1 for exactly one cycle, clears out_valid and A/B/M, and returns to QUEUE.
  - sweep_en stays high after done: no re-entry until sweep_en has been seen low for at least one edge.
- Sweep abort: if sweep_en=0 at an edge in SWEEP, next state = QUEUE, out_valid=0, A/B/M=0, and no sweep_done pulse. Abort takes priority over an accept in the same cycle.
- Reset mid-operation discards queued triples and any sweep in progress immediately.
- No arithmetic beyond the counter increment; the counter never wraps because termination precedes wrap.

Test Plan:
1. Reset then idle: after rst falls, in_ready=1, out_valid=0, count=0, A=B=M=0.
2. Push (A=3,B=5,M=0) with issue_ready=0: out_valid=1 two edges after push, A=3 B=5 M=0, held stable for 10 cycles; count=0.
3. Push 5 triples back-to-back with issue_ready=0: first goes to output, then FIFO fills. in_ready=0 with count=4; 6th push blocked. Raise issue_ready: triples appear in push order; out_valid=0 after the 5th accept.
4. Simultaneous push and accept with count=2: count stays 2, ordering preserved, no drop or duplicate.
5. sweep_en=1, issue_ready=1 from idle: {A,B,M} runs 0..511 in 512 consecutive cycles. sweep_done pulses once, the cycle after {F,F,1} is accepted. out_valid=0 afterwards; no restart while sweep_en stays high.
6. Abort and reset: drop sweep_en at value 37 -> out_valid=0, no sweep_done. Assert rst mid-sweep or with count=3 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/addsub_operand_issuer.sv
// addsub_operand_issuer
// Operand stage that drives A/B/M of the 4-bit adder_subtractor from
// registered outputs. Two modes of operation:
//   QUEUE : {A,B,M} triples arrive over in_valid/in_ready, are buffered in a
//           DEPTH-entry FIFO and issued in push order through a one-entry
//           output register (out_valid/issue_ready handshake).
//   SWEEP : the output register becomes a (2*WIDTH+1)-bit counter that walks
//           every {A,B,M} combination once, advancing on each accept.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_A/in_B/in_M the offered triple
//   sweep_en             request and hold an exhaustive sweep
//   issue_ready          downstream accepts the current A/B/M
//   A, B, M, out_valid   issued triple
//   count                FIFO occupancy, 0..DEPTH
//   sweep_done           one-cycle pulse after the last sweep value is accepted
module addsub_operand_issuer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_A,
  input  logic [WIDTH-1:0]           in_B,
  input  logic                       in_M,
  input  logic                       sweep_en,
  input  logic                       issue_ready,
  output logic [WIDTH-1:0]           A,
  output logic [WIDTH-1:0]           B,
  output logic                       M,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sweep_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {QUEUE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            sweep_done_q, sweep_done_d;
  logic            armed_q, armed_d;

  logic [TW-1:0]   mem [DEPTH];

  logic            push;
  logic            accept;
  logic            load;

  // Handshake qualifiers. A full FIFO refuses a push even when the head is
  // being drained in the same cycle, so in_ready depends on count alone.
  always_comb begin
    in_ready = (state_q == QUEUE) && (count_q < DEPTH_C);
    push     = in_valid && in_ready;
    accept   = out_valid_q && issue_ready;
    load     = (state_q == QUEUE) && (!out_valid_q || accept) && (count_q != '0);
  end

  // FIFO storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_A, in_B, in_M};
    end
  end

  // Next-state logic. armed_q blocks re-entry into SWEEP after a completed
  // sweep until sweep_en has been observed low at an edge.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    sweep_done_d = 1'b0;
    armed_d      = sweep_en ? armed_q : 1'b1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      QUEUE: begin
        if (load) begin
          out_d       = mem[rd_ptr_q];
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (accept) begin
          out_valid_d = 1'b0;
        end
        if (sweep_en && armed_q && (count_q == '0) && !out_valid_q) begin
          state_d     = SWEEP;
          out_d       = '0;
          out_valid_d = 1'b1;
        end
      end
      SWEEP: begin
        // Abort wins over an accept in the same cycle.
        if (!sweep_en) begin
          state_d     = QUEUE;
          out_d       = '0;
          out_valid_d = 1'b0;
        end else if (accept) begin
          if (out_q == '1) begin
            state_d      = QUEUE;
            out_d        = '0;
            out_valid_d  = 1'b0;
            sweep_done_d = 1'b1;
            armed_d      = 1'b0;
          end else begin
            out_d = out_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = QUEUE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= QUEUE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      sweep_done_q <= sweep_done_d;
      armed_q      <= armed_d;
    end
  end

  assign A          = out_q[TW-1 -: WIDTH];
  assign B          = out_q[WIDTH:1];
  assign M          = out_q[0];
  assign out_valid  = out_valid_q;
  assign count      = count_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_addsub_operand_issuer.sv
// tb_addsub_operand_issuer
// Drives addsub_operand_issuer with directed scenarios followed by random
// traffic. A queue-based reference model tracks the expected outputs and a
// compare process checks the DUT against it on every falling edge.
module tb_addsub_operand_issuer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic             in_M;
  logic             sweep_en;
  logic             issue_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             M;
  logic             out_valid;
  logic [2:0]       count;
  logic             sweep_done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model state
  logic [8:0] q[$];
  logic [8:0] m_out;
  bit         m_valid;
  bit         m_sweep;
  bit         m_armed;
  bit         m_done;

  addsub_operand_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_M(in_M),
    .sweep_en(sweep_en), .issue_ready(issue_ready),
    .A(A), .B(B), .M(M), .out_valid(out_valid),
    .count(count), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Wait for a falling edge, then drive all inputs.
  task automatic applyStimulus(input bit v, input int a, input int b, input bit m,
                               input bit ir, input bit se);
    @(negedge clk);
    in_valid    = v;
    in_A        = a[3:0];
    in_B        = b[3:0];
    in_M        = m;
    issue_ready = ir;
    sweep_en    = se;
  endtask

  function automatic int abm();
    return int'({A, B, M});
  endfunction

  function automatic int triple(input int a, input int b, input int m);
    return (a % 16) * 32 + (b % 16) * 2 + (m % 2);
  endfunction

  // Reference model: one step per rising edge, from the pre-edge model state
  // and the inputs the bench is driving.
  task automatic modelStep();
    bit accept;
    bit push;
    int pre_size;
    bit pre_valid;
    accept    = m_valid && issue_ready;
    pre_size  = q.size();
    pre_valid = m_valid;
    m_done    = 0;
    if (!m_sweep) begin
      push = in_valid && (pre_size < DEPTH);
      if ((!m_valid || accept) && pre_size > 0) begin
        m_out   = q.pop_front();
        m_valid = 1;
      end else if (accept) begin
        m_valid = 0;
      end
      if (push) q.push_back({in_A, in_B, in_M});
      if (sweep_en && m_armed && pre_size == 0 && !pre_valid) begin
        m_sweep = 1;
        m_out   = 0;
        m_valid = 1;
      end
    end else begin
      if (!sweep_en) begin
        m_sweep = 0;
        m_valid = 0;
        m_out   = 0;
      end else if (accept) begin
        if (m_out == 9'd511) begin
          m_sweep = 0;
          m_valid = 0;
          m_out   = 0;
          m_done  = 1;
          m_armed = 0;
        end else begin
          m_out = m_out + 9'd1;
        end
      end
    end
    if (!sweep_en) m_armed = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_out   = 0;
        m_valid = 0;
        m_sweep = 0;
        m_armed = 1;
        m_done  = 0;
      end else begin
        modelStep();
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out_valid", int'(out_valid), int'(m_valid));
      checkOutput("count", int'(count), q.size());
      checkOutput("in_ready", int'(in_ready), int'(!m_sweep && q.size() < DEPTH));
      checkOutput("sweep_done", int'(sweep_done), int'(m_done));
      if (m_valid) checkOutput("abm", abm(), int'(m_out));
    end
  end

  initial begin
    logic [8:0] got[$];
    int idx, first_cyc, last_cyc, done_cyc, done_cnt;
    bit found;
    bit se_r;

    rst = 0; in_valid = 0; in_A = 0; in_B = 0; in_M = 0;
    issue_ready = 0; sweep_en = 0;
    #2 rst = 1;
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // 1. Idle after reset
    $display("[TB] reset/idle");
    checkOutput("idle_in_ready", int'(in_ready), 1);
    checkOutput("idle_out_valid", int'(out_valid), 0);
    checkOutput("idle_count", int'(count), 0);
    checkOutput("idle_abm", abm(), 0);

    // 2. Single push, two-edge latency, held while not accepted
    $display("[TB] single push");
    applyStimulus(1, 3, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lat_one_edge_valid", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("lat_two_edge_valid", int'(out_valid), 1);
    checkOutput("single_abm", abm(), triple(3, 5, 0));
    checkOutput("single_count", int'(count), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_abm", abm(), triple(3, 5, 0));
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single_drained", int'(out_valid), 0);

    // 3. Five pushes back-to-back, sixth blocked, drain in order
    $display("[TB] fill fifo");
    for (int k = 1; k <= 5; k++) applyStimulus(1, k, k + 1, k[0], 0, 0);
    applyStimulus(1, 6, 7, 0, 0, 0);
    checkOutput("full_count", int'(count), 4);
    checkOutput("full_in_ready", int'(in_ready), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("blocked_count", int'(count), 4);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got.push_back({A, B, M});
      @(negedge clk);
    end
    checkOutput("drain_n", got.size(), 5);
    for (int k = 1; k <= 5; k++)
      if (got.size() >= k) checkOutput("drain_order", int'(got[k-1]), triple(k, k + 1, k % 2));
    checkOutput("drain_valid", int'(out_valid), 0);

    // 4. Push and accept in the same cycle with count=2
    $display("[TB] push+accept");
    applyStimulus(1, 10, 1, 1, 0, 0);
    applyStimulus(1, 11, 2, 0, 0, 0);
    applyStimulus(1, 12, 3, 1, 0, 0);
    applyStimulus(1, 13, 4, 0, 1, 0);
    checkOutput("pa_count_pre", int'(count), 2);
    checkOutput("pa_valid_pre", int'(out_valid), 1);
    for (int k = 14; k <= 16; k++) begin
      applyStimulus(1, k, k - 9, k[0], 1, 0);
      checkOutput("pa_count", int'(count), 2);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pa_count_last", int'(count), 2);
    repeat (8) @(negedge clk);
    checkOutput("pa_drained", int'(out_valid), 0);

    // 5. Full sweep
    $display("[TB] sweep");
    applyStimulus(0, 0, 0, 0, 1, 1);
    idx = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= 540; c++) begin
      @(negedge clk);
      if (sweep_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        if (abm() != idx) checkOutput("sweep_seq", abm(), idx);
        idx++;
      end
    end
    checkOutput("sweep_values", idx, 512);
    checkOutput("sweep_span", last_cyc - first_cyc, 511);
    checkOutput("sweep_done_cnt", done_cnt, 1);
    checkOutput("sweep_done_when", done_cyc, last_cyc + 1);
    checkOutput("sweep_no_restart", int'(out_valid), 0);

    // 6a. Abort at value 37
    $display("[TB] abort");
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (out_valid && abm() == 37) found = 1;
    end
    checkOutput("abort_reach37", int'(found), 1);
    sweep_en = 0;
    @(negedge clk);
    checkOutput("abort_valid", int'(out_valid), 0);
    checkOutput("abort_abm", abm(), 0);
    checkOutput("abort_done", int'(sweep_done), 0);

    // 6b. Asynchronous reset mid-sweep
    $display("[TB] reset mid-sweep");
    applyStimulus(0, 0, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checkOutput("rst_sweep_valid", int'(out_valid), 0);
    checkOutput("rst_sweep_abm", abm(), 0);
    checkOutput("rst_sweep_done", int'(sweep_done), 0);
    sweep_en = 0; issue_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // 6c. Asynchronous reset with count=3
    $display("[TB] reset with queued data");
    for (int k = 0; k < 4; k++) applyStimulus(1, k + 2, k + 7, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_q_count_pre", int'(count), 3);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checkOutput("rst_q_count", int'(count), 0);
    checkOutput("rst_q_valid", int'(out_valid), 0);
    checkOutput("rst_q_abm", abm(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // 7. Random traffic
    $display("[TB] random traffic");
    se_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) se_r = !se_r;
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), se_r);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
